// File: rtl/mazegen_pkg.sv
// Types shared by the maze/display datapath blocks.
// Owner encoding for the data-memory arbiter.
package mazegen_pkg;

    typedef enum logic {
        S_CPU = 1'b0,
        S_ENG = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU datapath and one engine.
// Ownership is registered; bounded burst/wait counters prevent starvation.
//
// state | meaning
// S_CPU | CPU drives memory; engine waits, wait_cnt counts contended cycles
// S_ENG | engine drives memory; CPU stalls only on lw/sw, burst_cnt counts accesses
module dmem_arbiter
    import mazegen_pkg::*;
#(
    parameter int Dbits    = 32,
    parameter int MaxBurst = 8,
    parameter int MaxWait  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             cpu_req,
    input  logic             cpu_wr,
    input  logic [Dbits-1:0] cpu_addr,
    input  logic [Dbits-1:0] cpu_wdata,
    output logic [Dbits-1:0] cpu_rdata,
    output logic             cpu_enable,
    input  logic             eng_req,
    input  logic             eng_wr,
    input  logic [Dbits-1:0] eng_addr,
    input  logic [Dbits-1:0] eng_wdata,
    output logic             eng_gnt,
    output logic [Dbits-1:0] eng_rdata,
    output logic [Dbits-1:0] mem_addr,
    output logic             mem_wr,
    output logic [Dbits-1:0] mem_wdata,
    input  logic [Dbits-1:0] mem_rdata
);

    localparam int BW = $clog2(MaxBurst + 1);
    localparam int WW = $clog2(MaxWait + 1);

    localparam logic [BW-1:0] BURST_MAX  = BW'(MaxBurst);
    localparam logic [BW-1:0] BURST_LAST = BW'(MaxBurst - 1);
    localparam logic [WW-1:0] WAIT_MAX   = WW'(MaxWait);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(MaxWait - 1);

    arb_state_t        state_q, state_d;
    logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
    logic              is_eng;

    assign is_eng = (state_q == S_ENG);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_CPU;
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            S_CPU: begin
                if (eng_req && (!cpu_req || wait_cnt_q == WAIT_LAST)) begin
                    state_d     = S_ENG;
                    wait_cnt_d  = '0;
                    burst_cnt_d = '0;
                end else if (eng_req && cpu_req) begin
                    if (wait_cnt_q != WAIT_MAX) begin
                        wait_cnt_d = wait_cnt_q + WW'(1);
                    end
                end else begin
                    wait_cnt_d = '0;
                end
            end
            S_ENG: begin
                wait_cnt_d = '0;
                if (!eng_req) begin
                    state_d     = S_CPU;
                    burst_cnt_d = '0;
                end else begin
                    if (burst_cnt_q != BURST_MAX) begin
                        burst_cnt_d = burst_cnt_q + BW'(1);
                    end
                    // The engine finishes this access even when it is the one that hits the limit.
                    if (cpu_req && (burst_cnt_q == BURST_LAST || burst_cnt_q == BURST_MAX)) begin
                        state_d     = S_CPU;
                        burst_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d     = S_CPU;
                wait_cnt_d  = '0;
                burst_cnt_d = '0;
            end
        endcase
    end

    assign eng_gnt    = is_eng;
    assign cpu_enable = ~reset & run & ~(is_eng & cpu_req);
    assign mem_addr   = is_eng ? eng_addr : cpu_addr;
    assign mem_wdata  = is_eng ? eng_wdata : cpu_wdata;
    assign mem_wr     = ~reset & (is_eng ? (eng_req & eng_wr) : (cpu_req & cpu_wr & run));
    assign cpu_rdata  = mem_rdata;
    assign eng_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against an
// ownership model kept in terms of "cycles waited" and "accesses this tenure".
module tb_dmem_arbiter;

    localparam int DW        = 32;
    localparam int MAX_BURST = 4;
    localparam int MAX_WAIT  = 3;

    logic          clk, reset, run;
    logic          cpu_req, cpu_wr;
    logic [DW-1:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic          cpu_enable;
    logic          eng_req, eng_wr;
    logic [DW-1:0] eng_addr, eng_wdata, eng_rdata;
    logic          eng_gnt;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
    logic          mem_wr;

    dmem_arbiter #(.Dbits(DW), .MaxBurst(MAX_BURST), .MaxWait(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .run(run),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_enable(cpu_enable),
        .eng_req(eng_req), .eng_wr(eng_wr), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_gnt(eng_gnt), .eng_rdata(eng_rdata),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] init_word(int i);
        return 32'h1000_0000 + 32'(i) * 32'h11;
    endfunction

    // Physical memory driven only by the DUT's memory port.
    logic [DW-1:0] phys_mem [16];
    logic          mem_clear;
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 16; i++) phys_mem[i] <= init_word(i);
        end else if (mem_wr) begin
            phys_mem[mem_addr[3:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = phys_mem[mem_addr[3:0]];

    // Reference model
    logic [DW-1:0] ref_mem [16];
    bit            m_eng;
    int            m_waited;
    int            m_done;

    int n_checks = 0;
    int n_errors = 0;
    bit obs_gnt, obs_en, obs_acc;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input bit rn, input bit creq, input bit cwr,
                         input logic [DW-1:0] caddr, input logic [DW-1:0] cwd,
                         input bit ereq, input bit ewr,
                         input logic [DW-1:0] eaddr, input logic [DW-1:0] ewd);
        reset = rst; run = rn;
        cpu_req = creq; cpu_wr = cwr; cpu_addr = caddr; cpu_wdata = cwd;
        eng_req = ereq; eng_wr = ewr; eng_addr = eaddr; eng_wdata = ewd;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        bit            exp_en, exp_wr;
        logic [DW-1:0] sel_addr, sel_wdata;
        #1;
        exp_en    = !reset && run && !(m_eng && cpu_req);
        exp_wr    = !reset && (m_eng ? (eng_req && eng_wr) : (cpu_req && cpu_wr && run));
        sel_addr  = m_eng ? eng_addr : cpu_addr;
        sel_wdata = m_eng ? eng_wdata : cpu_wdata;
        chk("eng_gnt", eng_gnt, m_eng);
        chk("cpu_enable", cpu_enable, exp_en);
        chk("mem_wr", mem_wr, exp_wr);
        chk("mem_addr", mem_addr, sel_addr);
        if (exp_wr) chk("mem_wdata", mem_wdata, sel_wdata);
        chk("cpu_rdata", cpu_rdata, ref_mem[sel_addr[3:0]]);
        chk("eng_rdata", eng_rdata, ref_mem[sel_addr[3:0]]);
        obs_gnt = eng_gnt;
        obs_en  = cpu_enable;
        obs_acc = eng_gnt & eng_req;

        if (exp_wr) ref_mem[sel_addr[3:0]] = sel_wdata;
        if (reset) begin
            m_eng = 0; m_waited = 0; m_done = 0;
        end else if (!m_eng) begin
            if (eng_req && (!cpu_req || m_waited + 1 >= MAX_WAIT)) begin
                m_eng = 1; m_waited = 0; m_done = 0;
            end else if (eng_req && cpu_req) begin
                m_waited++;
            end else begin
                m_waited = 0;
            end
        end else begin
            if (!eng_req) begin
                m_eng = 0;
            end else begin
                m_done++;
                if (cpu_req && m_done >= MAX_BURST) m_eng = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    int acc, stall;

    initial begin
        mem_clear = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        m_eng = 0; m_waited = 0; m_done = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        mem_clear = 1'b0;
        cycle();
        chk("rst_gnt", eng_gnt, 0);

        // Engine alone: write then read back
        drive(0, 1, 0, 0, 0, 0, 1, 1, 32'h100, 32'hA5A5A5A5);
        cycle();
        chk("t1_gnt_t0", obs_gnt, 0);
        cycle();
        chk("t1_gnt_t1", obs_gnt, 1);
        chk("t1_wr_t1", obs_acc, 1);
        drive(0, 1, 0, 0, 0, 0, 1, 0, 32'h100, 0);
        #1;
        chk("t1_readback", eng_rdata, 32'hA5A5A5A5);
        cycle();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // CPU lw every cycle with engine contending
        drive(0, 1, 1, 0, 32'h3, 0, 1, 1, 32'h5, 32'h5555_0000);
        for (int t = 0; t < 4; t++) begin
            cycle();
            chk("t2_gnt", obs_gnt, (t == 3));
            chk("t2_enable", obs_en, (t < 3));
        end

        // Continuing burst under continuous cpu_req
        acc = 1; stall = 1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (!obs_gnt) break;
            acc += obs_acc;
            stall += !obs_en;
        end
        chk("t3_accesses", acc, MAX_BURST);
        chk("t3_stall", stall, MAX_BURST);
        chk("t3_cpu_slot", obs_en, 1);

        // ALU-only CPU: engine keeps ownership beyond the burst limit
        cpu_req = 0;
        cycle();
        for (int i = 0; i < 8; i++) begin
            eng_wdata = 32'hE000_0000 + 32'(i);
            cycle();
            chk("t4_gnt", obs_gnt, 1);
            chk("t4_enable", obs_en, 1);
        end
        cpu_req = 1;
        cycle();
        chk("t4_yield_acc", obs_acc, 1);
        chk("t4_yield_en", obs_en, 0);
        cycle();
        chk("t4_yielded", obs_gnt, 0);

        // CPU sw with run=0 is dropped
        drive(0, 0, 1, 1, 32'h7, 32'hDEADBEEF, 0, 0, 0, 0);
        cycle();
        drive(0, 1, 1, 0, 32'h7, 0, 0, 0, 0, 0);
        #1;
        chk("t5_mem_kept", cpu_rdata, 32'h1000_0077);
        cycle();

        // Reset in the middle of an engine write burst
        drive(0, 1, 0, 0, 0, 0, 1, 1, 32'h9, 32'h9999_0001);
        cycle();
        cycle();
        chk("t6_gnt_before", obs_gnt, 1);
        eng_wdata = 32'h9999_0002;
        reset = 1;
        #1;
        chk("t6_wr_in_reset", mem_wr, 0);
        chk("t6_en_in_reset", cpu_enable, 0);
        cycle();
        chk("t6_gnt_after", eng_gnt, 0);
        chk("t6_state", 32'(dut.state_q), 0);
        chk("t6_burst", 32'(dut.burst_cnt_q), 0);
        chk("t6_wait", 32'(dut.wait_cnt_q), 0);
        chk("t6_mem9", phys_mem[9], 32'h9999_0001);
        reset = 0;
        eng_req = 0;
        cycle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            run       = ($urandom_range(0, 7) != 0);
            cpu_req   = ($urandom_range(0, 2) != 0);
            cpu_wr    = $urandom_range(0, 1);
            cpu_addr  = 32'($urandom_range(0, 15));
            cpu_wdata = $urandom;
            cycle();
            if (!eng_req || obs_acc) begin
                eng_req   = ($urandom_range(0, 9) < 7);
                eng_wr    = $urandom_range(0, 1);
                eng_addr  = 32'($urandom_range(0, 15));
                eng_wdata = $urandom;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
